// File: rtl/ram_turbo_arbiter.sv
// -----------------------------------------------------------------------------
// ram_turbo_arbiter
// Round-robin fast-path arbiter that lets up to PORTS bus masters use the
// shared SRAM in 7 MHz slots the chipset leaves idle. One transaction occupies
// exactly one slot (4 clk_sys cycles); a slot reclaimed by the chipset aborts
// the transaction and the grantee keeps its priority for the retry.
//
// Ports
//   clk_sys, reset     28 MHz system clock, synchronous active-high reset
//   clk7_en            slot boundary strobe (one cycle in four)
//   chip_busy          chipset owns the SRAM in the current slot
//   turbo_en[PORTS]    per-port enable, masks req
//   req/we[PORTS]      request (held until ack) and write flag
//   addr/wdata/be      per-port address, write data, byte enables (packed)
//   ack[PORTS]         one-cycle completion pulse
//   rdata              read data, valid in the ack cycle
//   ram_*              registered SRAM control/address/data, ram_rdata return
// -----------------------------------------------------------------------------
module ram_turbo_arbiter #(
    parameter int unsigned PORTS = 2,
    parameter int unsigned AW    = 23
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  clk7_en,
    input  logic                  chip_busy,
    input  logic [PORTS-1:0]      turbo_en,
    input  logic [PORTS-1:0]      req,
    input  logic [PORTS-1:0]      we,
    input  logic [PORTS*AW-1:0]   addr,
    input  logic [PORTS*16-1:0]   wdata,
    input  logic [PORTS*2-1:0]    be,
    output logic [PORTS-1:0]      ack,
    output logic [15:0]           rdata,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [AW-1:0]         ram_addr,
    output logic [15:0]           ram_wdata,
    output logic [1:0]            ram_be,
    input  logic [15:0]           ram_rdata
);

    localparam int unsigned PW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } txn_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n;
    logic [PW-1:0]    grantee, grantee_n;
    logic [PORTS-1:0] ack_n;
    logic [DW-1:0]    rdata_n;
    logic             cs_n, we_n;
    logic [AW-1:0]    addr_n;
    logic [DW-1:0]    wdata_n;
    logic [BW-1:0]    be_n;

    logic [PORTS-1:0] eligible;
    logic [PORTS-1:0] grant_mask;
    logic [PW-1:0]    grant_base;
    logic             grant_ok;
    logic [PW:0]      pick;
    txn_t             port_txn [PORTS];

    // Unpack the flat per-port buses into one payload per port
    for (genvar i = 0; i < PORTS; i++) begin : g_unpack
        assign port_txn[i] = '{we:    we[i],
                               addr:  addr[i*AW +: AW],
                               wdata: wdata[i*DW +: DW],
                               be:    be[i*BW +: BW]};
    end

    // First set bit of mask at or after base, wrapping; returns {valid, index}
    function automatic logic [PW:0] rr_pick(input logic [PORTS-1:0] mask,
                                            input logic [PW-1:0]    base);
        logic [PW:0] r;
        int unsigned idx;
        r = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            idx = (32'(base) + k) % PORTS;
            if (!r[PW] && mask[PW'(idx)]) r = {1'b1, PW'(idx)};
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
        return PW'((32'(p) + 32'd1) % PORTS);
    endfunction

    assign eligible = req & turbo_en;

    // Next-state and registered-output values
    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        grantee_n  = grantee;
        ack_n      = '0;
        rdata_n    = rdata;
        cs_n       = ram_cs;
        we_n       = ram_we;
        addr_n     = ram_addr;
        wdata_n    = ram_wdata;
        be_n       = ram_be;
        grant_ok   = 1'b0;
        grant_base = ptr;
        grant_mask = eligible;

        case (state)
            IDLE: begin
                cs_n     = 1'b0;
                we_n     = 1'b0;
                grant_ok = clk7_en & ~chip_busy;
            end
            ISSUE: begin
                if (chip_busy) begin
                    // Chipset reclaimed the slot: drop the access, keep ptr
                    state_n = IDLE;
                    cs_n    = 1'b0;
                    we_n    = 1'b0;
                end else if (clk7_en) begin
                    ack_n[grantee] = 1'b1;
                    if (!ram_we) rdata_n = ram_rdata;
                    ptr_n      = next_port(grantee);
                    state_n    = IDLE;
                    cs_n       = 1'b0;
                    we_n       = 1'b0;
                    grant_ok   = 1'b1;
                    grant_base = next_port(grantee);
                    // The finishing port still shows req this edge (it only
                    // sees ack afterwards), so it may not be re-granted here.
                    grant_mask = eligible & ~(PORTS'(1) << grantee);
                end
            end
            default: state_n = IDLE;
        endcase

        pick = rr_pick(grant_mask, grant_base);
        if (grant_ok && pick[PW]) begin
            state_n   = ISSUE;
            grantee_n = pick[PW-1:0];
            cs_n      = 1'b1;
            we_n      = port_txn[pick[PW-1:0]].we;
            addr_n    = port_txn[pick[PW-1:0]].addr;
            wdata_n   = port_txn[pick[PW-1:0]].wdata;
            be_n      = port_txn[pick[PW-1:0]].be;
        end
    end

    // State and output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grantee   <= '0;
            ack       <= '0;
            rdata     <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_be    <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            grantee   <= grantee_n;
            ack       <= ack_n;
            rdata     <= rdata_n;
            ram_cs    <= cs_n;
            ram_we    <= we_n;
            ram_addr  <= addr_n;
            ram_wdata <= wdata_n;
            ram_be    <= be_n;
        end
    end

endmodule
